fpu_sched: RTL
==============

Name: fpu_sched

Overview:
- Sequences the single, non-pipelined multi-cycle FPU in the EX stage.
- Accepts one FP op at a time from ID/EX and counts down its class latency.
- Arbitrates the single FP register-file write port between FP-load writeback (always wins) and FPU results.
- Drives ID stall outputs for busy and for read-after-write on the in-flight destination.

Parameters:
- LAT_ADD, 3, cycles for class 0 (add/sub/cmp/cvt/misc) and class 3; minimum 1.
- LAT_MUL, 4, cycles for class 1 (mul/fma); minimum 1.
- LAT_DIV, 16, cycles for class 2 (div/sqrt); minimum 1.
- CNT_W, 5, down-counter width; must satisfy 2^CNT_W > max(LAT_*).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  EX presents an FPU op this cycle
- issue_op  in  2  latency class: 0 ADD, 1 MUL, 2 DIV, 3 treated as ADD
- issue_rd  in  5  FP destination register
- issue_kill  in  1  flush; cancels a same-cycle issue
- issue_ready  out  1  scheduler can accept an op
- fpu_start  out  1  one-cycle pulse: FPU latches operands
- busy  out  1  op in flight (state != IDLE)
- id_rs  in  15  {rs3, rs2, rs1} of the instruction in ID
- id_rs_used  in  3  per-source FP-read mask {rs3, rs2, rs1}
- raw_stall  out  1  ID must hold
- load_wen  in  1  FP load writes back this cycle
- load_rd  in  5  FP load destination
- fp_regwen  out  1  FP regfile write enable
- fp_wa  out  5  FP regfile write address
- fp_wsel  out  1  write-data select: 0 load data, 1 FPU result
- done  out  1  pulse on the cycle an FPU result is retired (written or dropped)

Behaviour:
- States: IDLE, EXEC, HOLD. Registers: state, cnt[CNT_W], pend_rd[5], drop.
- Accept condition: issue_valid && issue_ready && !issue_kill.
- issue_ready = (state==IDLE).
- fpu_start = accept, combinational in the accept cycle c0.
- On accept:
  - state <= EXEC, pend_rd <= issue_rd, drop <= 0.
  - cnt <= LAT(class) - 1.
- EXEC:
  - If cnt != 0: cnt decrements.
  - If cnt == 0 (cycle c0+LAT), the result is ready. It retires this cycle if !load_wen, otherwise state <= HOLD.
- HOLD: retires on the first cycle with !load_wen.
- Retire cycle:
  - fp_regwen = !drop, fp_wa = pend_rd, fp_wsel = 1, done = 1.
  - state <= IDLE.
  - The next accept is possible in the following cycle.
- Load path has priority every cycle: load_wen=1 forces fp_regwen=1, fp_wa=load_rd, fp_wsel=0, with no retire that cycle.
- Write-after-write (WAW): load_wen && load_rd==pend_rd while in EXEC or HOLD sets drop <= 1. The load is younger, so the FPU result must not overwrite it.
- If this WAW load arrives in the same cycle the result would retire, retirement is deferred to HOLD as normal and the write is then suppressed.
- raw_stall = (state != IDLE) && !drop && any i with id_rs_used[i] && id_rs[i]==pend_rd, OR issue_valid && !issue_ready.
- Stall holds through the retire cycle itself; there is no bypass.
- Idle-cycle outputs: fp_regwen = load_wen, fp_wa = load_rd, fp_wsel = 0.
- Reset: state IDLE, cnt 0, pend_rd 0, drop 0.
  - Outputs after reset: issue_ready=1, busy=0, fpu_start=0, done=0, raw_stall=0 (absent issue_valid), fp_regwen=load_wen.
  - Reset mid-operation discards the in-flight op with no write and no done.
- issue_kill while busy has no effect on the in-flight op; issued ops are committed.

Test Plan:
- Reset, then issue op=0 rd=5 at c0 with LAT_ADD=3 -> fpu_start at c0; busy c1..c3; at c3 fp_regwen=1, fp_wa=5, fp_wsel=1, done=1; issue_ready=1 at c4.
- op=2 rd=7 accepted; id_rs_used=001, rs1=7 during EXEC -> raw_stall=1 for all LAT_DIV cycles including retire; rs1=8 -> raw_stall=0.
- op=1 rd=3; load_wen=1 load_rd=9 on cycles c4 and c5 (retire due c4) -> loads written with fp_wsel=0; FPU write at c6 with fp_wa=3.
- op=1 rd=3; load_wen=1 load_rd=3 at c2 -> at c4 done=1, fp_regwen=0; raw_stall on rs=3 clears from c3.
- issue_valid with issue_kill=1 -> no fpu_start, state stays IDLE; a second issue while busy -> issue_ready=0, raw_stall=1, no restart.
- rst asserted at c2 of a DIV op -> next cycle busy=0, issue_ready=1; no fp_regwen or done for that op.

Source files
------------

// File: rtl/fpu_sched.sv
// fpu_sched: sequencer for the single, non-pipelined multi-cycle FPU in EX.
//
// Accepts one FP op at a time, counts down its latency class, then retires
// the result through the single FP register-file write port. FP-load
// writeback owns that port whenever it is active, so a ready result waits
// (HOLD) until the port is free. A load to the in-flight destination makes
// the FPU result stale, so its write is dropped while it still retires.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   issue_valid/op/rd/kill, issue_ready, fpu_start   EX issue handshake
//   busy             op in flight
//   id_rs, id_rs_used, raw_stall                     ID hazard interface
//   load_wen, load_rd                                FP load writeback
//   fp_regwen, fp_wa, fp_wsel                        FP regfile write port
//   done             pulse when an FPU result retires (written or dropped)
module fpu_sched #(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [1:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic        issue_kill,
  output logic        issue_ready,
  output logic        fpu_start,
  output logic        busy,
  input  logic [14:0] id_rs,
  input  logic [2:0]  id_rs_used,
  output logic        raw_stall,
  input  logic        load_wen,
  input  logic [4:0]  load_rd,
  output logic        fp_regwen,
  output logic [4:0]  fp_wa,
  output logic        fp_wsel,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Counter reload values: the accept cycle itself counts as the first cycle.
  localparam logic [CNT_W-1:0] ADD_M1 = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(LAT_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             drop_q, drop_d;

  logic             accept;
  logic             result_rdy;
  logic             retire;
  logic             waw;
  logic [CNT_W-1:0] lat_m1;
  logic [2:0]       rs_hit;

  assign issue_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign accept      = issue_valid && issue_ready && !issue_kill;
  assign fpu_start   = accept;

  // Result is ready at the last EXEC count, or has been waiting in HOLD.
  assign result_rdy = ((state_q == S_EXEC) && (cnt_q == '0)) || (state_q == S_HOLD);
  // Load writeback always owns the port; the result retires only when it is free.
  assign retire     = result_rdy && !load_wen;
  assign waw        = busy && load_wen && (load_rd == pend_rd_q);

  always_comb begin
    lat_m1 = ADD_M1;
    case (issue_op)
      2'd1:    lat_m1 = MUL_M1;
      2'd2:    lat_m1 = DIV_M1;
      default: lat_m1 = ADD_M1;
    endcase
  end

  // Per-source RAW compare against the in-flight destination.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rs_hit
      assign rs_hit[gi] = id_rs_used[gi] && (id_rs[5*gi +: 5] == pend_rd_q);
    end
  endgenerate

  // A dropped result no longer produces the register, so it cannot cause RAW.
  assign raw_stall = (busy && !drop_q && (|rs_hit)) || (issue_valid && !issue_ready);

  // Write port mux: load first, then a retiring (non-dropped) result.
  assign fp_regwen = load_wen || (retire && !drop_q);
  assign fp_wa     = load_wen ? load_rd : (retire ? pend_rd_q : load_rd);
  assign fp_wsel   = !load_wen && retire;
  assign done      = retire;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    drop_d    = drop_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_EXEC;
          cnt_d     = lat_m1;
          pend_rd_d = issue_rd;
          drop_d    = 1'b0;
        end
      end
      S_EXEC: begin
        if (waw) drop_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (retire) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (waw) drop_d = 1'b1;
        if (retire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_rd_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
      drop_q    <= drop_d;
    end
  end

endmodule
